// File: rtl/contador_gray_param.sv
// Parametrised up/down Gray-code counter with synchronous load, wrap/saturate
// modes, terminal-count indication, one-cycle wrap pulse and sticky overflow.
module contador_gray_param #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             wrap_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] salida_bin,
    output logic [WIDTH-1:0] salida_gray,
    output logic             terminal,
    output logic             wrap_pulse,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_COUNT  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_COUNT = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_COUNT  = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] bin_v);
        return bin_v ^ (bin_v >> 1);
    endfunction

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic             ovf_r;

    logic [WIDTH-1:0] next_count_s;
    logic             next_wrap_s;
    logic             next_ovf_s;
    logic             terminal_s;

    // Terminal depends on the live direction so a direction change is seen at once
    always_comb begin
        if (up_down) begin
            terminal_s = (count_r == MAX_COUNT);
        end else begin
            terminal_s = (count_r == ZERO_COUNT);
        end
    end

    // Next-state selection: load beats enable; at terminal either wrap or hold
    always_comb begin
        next_count_s = count_r;
        next_wrap_s  = 1'b0;
        next_ovf_s   = ovf_r;
        if (load) begin
            next_count_s = load_value;
            next_ovf_s   = 1'b0;
        end else if (enable) begin
            if (terminal_s) begin
                next_ovf_s = 1'b1;
                if (wrap_mode) begin
                    next_count_s = up_down ? ZERO_COUNT : MAX_COUNT;
                    next_wrap_s  = 1'b1;
                end else begin
                    next_count_s = count_r;
                end
            end else begin
                next_count_s = up_down ? (count_r + ONE_COUNT) : (count_r - ONE_COUNT);
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // State registers; Gray is derived from the same next value so both outputs move together
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO_COUNT;
            gray_r  <= ZERO_COUNT;
            wrap_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= next_count_s;
            gray_r  <= bin_to_gray(next_count_s);
            wrap_r  <= next_wrap_s;
            ovf_r   <= next_ovf_s;
        end
    end

    assign salida_bin  = count_r;
    assign salida_gray = gray_r;
    assign terminal    = terminal_s;
    assign wrap_pulse  = wrap_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_contador_gray_param.sv
// Scoreboard bench for contador_gray_param: WIDTH=5 and WIDTH=2 instances share
// stimulus; a bench-side model pushes expected outputs each cycle.
module tb_contador_gray_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic       wrap_mode = 1'b1;
    logic       load = 1'b0;
    logic [4:0] load_value = 5'd0;

    logic [4:0] d5_bin, d5_gray;
    logic       d5_term, d5_wrap, d5_ovf;
    logic [1:0] d2_bin, d2_gray;
    logic       d2_term, d2_wrap, d2_ovf;

    int checks = 0;
    int failures = 0;

    logic [11:0] sb5[$];
    logic [5:0]  sb2[$];
    logic [15:0] m_count[2];
    logic        m_ovf[2];

    wire [11:0] obs5 = {d5_bin, d5_gray, d5_wrap, d5_ovf};
    wire [5:0]  obs2 = {d2_bin, d2_gray, d2_wrap, d2_ovf};

    always #5 clk = ~clk;

    contador_gray_param #(.WIDTH(5)) dut5 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .wrap_mode(wrap_mode), .load(load), .load_value(load_value),
        .salida_bin(d5_bin), .salida_gray(d5_gray), .terminal(d5_term),
        .wrap_pulse(d5_wrap), .overflow(d5_ovf)
    );

    contador_gray_param #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .wrap_mode(wrap_mode), .load(load), .load_value(load_value[1:0]),
        .salida_bin(d2_bin), .salida_gray(d2_gray), .terminal(d2_term),
        .wrap_pulse(d2_wrap), .overflow(d2_ovf)
    );

    // Compute expected results from current inputs, push them, then clock once
    task automatic tick();
        logic [15:0] mx, c, g;
        logic o, w;
        for (int k = 0; k < 2; k++) begin
            mx = (k == 0) ? 16'd31 : 16'd3;
            c  = m_count[k];
            o  = m_ovf[k];
            w  = 1'b0;
            if (reset) begin
                c = 16'd0;
                o = 1'b0;
            end else if (load) begin
                c = {11'd0, load_value} & mx;
                o = 1'b0;
            end else if (enable) begin
                if ((up_down && c == mx) || (!up_down && c == 16'd0)) begin
                    o = 1'b1;
                    if (wrap_mode) begin
                        c = up_down ? 16'd0 : mx;
                        w = 1'b1;
                    end
                end else begin
                    c = up_down ? ((c + 16'd1) & mx) : ((c - 16'd1) & mx);
                end
            end
            m_count[k] = c;
            m_ovf[k]   = o;
            g = c ^ (c >> 1);
            if (k == 0) sb5.push_back({c[4:0], g[4:0], w, o});
            else        sb2.push_back({c[1:0], g[1:0], w, o});
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pop5();
        if (sb5.size() == 0) return 12'hxxx;
        return sb5.pop_front();
    endfunction

    function automatic logic [5:0] pop2();
        if (sb2.size() == 0) return 6'bxxxxxx;
        return sb2.pop_front();
    endfunction

    task automatic test_reset();
        logic [11:0] e;
        reset = 1'b1; enable = 1'b1; up_down = 1'b1; wrap_mode = 1'b1; load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = pop5();
            checks++;
            if (obs5 !== e) begin failures++; $display("FAIL reset_sb[%0d] got=%h want=%h", i, obs5, e); end
        end
        checks++;
        if (obs5 !== 12'h000) begin failures++; $display("FAIL reset_zero got=%h want=000", obs5); end
        checks++;
        if (d5_term !== 1'b0) begin failures++; $display("FAIL reset_term_up got=%b want=0", d5_term); end
        up_down = 1'b0;
        #1;
        checks++;
        if (d5_term !== 1'b1) begin failures++; $display("FAIL reset_term_down got=%b want=1", d5_term); end
        up_down = 1'b1;
        reset = 1'b0;
    endtask

    task automatic test_up_count();
        logic [11:0] e;
        logic [4:0]  prev_g;
        logic [4:0]  gtab [4] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110};
        enable = 1'b1; up_down = 1'b1; wrap_mode = 1'b1;
        prev_g = d5_gray;
        for (int i = 1; i <= 33; i++) begin
            tick();
            e = pop5();
            checks++;
            if (obs5 !== e) begin failures++; $display("FAIL up_sb[%0d] got=%h want=%h", i, obs5, e); end
            checks++;
            if ($countones(prev_g ^ d5_gray) != 1) begin
                failures++; $display("FAIL up_gray_step[%0d] got=%b prev=%b want one bit change", i, d5_gray, prev_g);
            end
            prev_g = d5_gray;
            if (i <= 4) begin
                checks++;
                if (d5_gray !== gtab[i-1]) begin failures++; $display("FAIL up_gray_seq[%0d] got=%b want=%b", i, d5_gray, gtab[i-1]); end
            end
            if (i == 31) begin
                checks++;
                if ({d5_gray, d5_term} !== {5'b10000, 1'b1}) begin
                    failures++; $display("FAIL up_at_max got=%b/%b want=10000/1", d5_gray, d5_term);
                end
            end
            if (i == 32) begin
                checks++;
                if ({d5_bin, d5_wrap, d5_ovf} !== {5'd0, 1'b1, 1'b1}) begin
                    failures++; $display("FAIL up_wrap got=%0d/%b/%b want=0/1/1", d5_bin, d5_wrap, d5_ovf);
                end
            end
            if (i == 33) begin
                checks++;
                if (d5_wrap !== 1'b0) begin failures++; $display("FAIL up_wrap_one_cycle got=%b want=0", d5_wrap); end
            end
        end
    endtask

    task automatic test_down_wrap();
        logic [11:0] e;
        enable = 1'b0; load = 1'b1; load_value = 5'd0;
        tick();
        e = pop5();
        checks++;
        if (obs5 !== e) begin failures++; $display("FAIL down_load_sb got=%h want=%h", obs5, e); end
        checks++;
        if (d5_ovf !== 1'b0) begin failures++; $display("FAIL down_load_ovf got=%b want=0", d5_ovf); end
        load = 1'b0; up_down = 1'b0;
        #1;
        checks++;
        if (d5_term !== 1'b1) begin failures++; $display("FAIL down_term got=%b want=1", d5_term); end
        enable = 1'b1;
        tick();
        e = pop5();
        checks++;
        if (obs5 !== e) begin failures++; $display("FAIL down_step_sb got=%h want=%h", obs5, e); end
        checks++;
        if ({d5_bin, d5_gray, d5_wrap} !== {5'd31, 5'b10000, 1'b1}) begin
            failures++; $display("FAIL down_wrap got=%0d/%b/%b want=31/10000/1", d5_bin, d5_gray, d5_wrap);
        end
        enable = 1'b0;
        tick();
        e = pop5();
        checks++;
        if (obs5 !== e) begin failures++; $display("FAIL down_hold_sb got=%h want=%h", obs5, e); end
    endtask

    task automatic test_saturate();
        logic [11:0] e;
        logic [4:0]  btab [3] = '{5'd31, 5'd31, 5'd31};
        logic        otab [3] = '{1'b0, 1'b1, 1'b1};
        wrap_mode = 1'b0; enable = 1'b0; load = 1'b1; load_value = 5'd30;
        tick();
        e = pop5();
        checks++;
        if (obs5 !== e) begin failures++; $display("FAIL sat_load_sb got=%h want=%h", obs5, e); end
        load = 1'b0; up_down = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = pop5();
            checks++;
            if (obs5 !== e) begin failures++; $display("FAIL sat_sb[%0d] got=%h want=%h", i, obs5, e); end
            checks++;
            if ({d5_bin, d5_wrap, d5_ovf} !== {btab[i], 1'b0, otab[i]}) begin
                failures++; $display("FAIL sat_step[%0d] got=%0d/%b/%b want=%0d/0/%b", i, d5_bin, d5_wrap, d5_ovf, btab[i], otab[i]);
            end
        end
    endtask

    task automatic test_load_priority();
        logic [11:0] e;
        wrap_mode = 1'b1; up_down = 1'b1; enable = 1'b1; load = 1'b1; load_value = 5'd5;
        tick();
        e = pop5();
        checks++;
        if (obs5 !== e) begin failures++; $display("FAIL prio_load_sb got=%h want=%h", obs5, e); end
        checks++;
        if (obs5 !== {5'd5, 5'b00111, 1'b0, 1'b0}) begin
            failures++; $display("FAIL prio_load got=%h want=%h", obs5, {5'd5, 5'b00111, 1'b0, 1'b0});
        end
        reset = 1'b1;
        tick();
        e = pop5();
        checks++;
        if (d5_bin !== 5'd0 || obs5 !== e) begin
            failures++; $display("FAIL prio_reset got=%h want=%h", obs5, e);
        end
        reset = 1'b0; load = 1'b0;
    endtask

    task automatic test_width2();
        logic [5:0] e;
        logic [1:0] gtab [8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        int wraps;
        sb2.delete();
        reset = 1'b1; load = 1'b0; enable = 1'b1; up_down = 1'b1; wrap_mode = 1'b1;
        tick();
        void'(pop5());
        e = pop2();
        checks++;
        if (obs2 !== e || d2_gray !== 2'b00) begin failures++; $display("FAIL w2_reset got=%h want=%h", obs2, e); end
        reset = 1'b0;
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            void'(pop5());
            e = pop2();
            checks++;
            if (obs2 !== e) begin failures++; $display("FAIL w2_sb[%0d] got=%h want=%h", i, obs2, e); end
            checks++;
            if (d2_gray !== gtab[i] || d2_wrap !== (i % 4 == 3)) begin
                failures++; $display("FAIL w2_seq[%0d] got=%b/%b want=%b/%b", i, d2_gray, d2_wrap, gtab[i], (i % 4 == 3));
            end
            if (d2_wrap === 1'b1) wraps++;
        end
        checks++;
        if (wraps != 2) begin failures++; $display("FAIL w2_wrap_count got=%0d want=2", wraps); end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_saturate();
        test_load_priority();
        test_width2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
